// File: rtl/proc_cfg_sequencer_pkg.sv
// Shared constants and types for the configuration sequencer: processor register
// map, host register map and the sequencer state encoding.
package proc_cfg_sequencer_pkg;

  localparam logic [4:0] PROC_MODE_ADDR    = 5'h00;
  localparam logic [4:0] PROC_KERNEL_BASE  = 5'h04;
  localparam logic [4:0] PROC_STATUS_ADDR  = 5'h10;
  localparam logic [7:0] STATUS_MAGIC      = 8'hAA;

  localparam logic [4:0] HOST_MODE_ADDR    = 5'h00;
  localparam logic [4:0] HOST_KERNEL_FIRST = 5'h04;
  localparam logic [4:0] HOST_KERNEL_LAST  = 5'h0C;
  localparam logic [4:0] HOST_CTRL_ADDR    = 5'h10;
  localparam logic [4:0] HOST_STATUS_ADDR  = 5'h11;
  localparam logic [4:0] HOST_FCOUNT_ADDR  = 5'h12;

  localparam int         KERNEL_TAPS       = 9;
  localparam logic [3:0] LAST_WRITE_IDX    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE_STREAM,
    ST_WAIT_EOF,
    ST_WRITE,
    ST_CHECK
  } seq_state_t;

  function automatic logic is_kernel_addr(input logic [4:0] addr);
    return (addr >= HOST_KERNEL_FIRST) && (addr <= HOST_KERNEL_LAST);
  endfunction

endpackage

// File: rtl/proc_cfg_sequencer_pix_counter.sv
// Per-frame pixel counter: counts accepted pixels, flags the last pixel of a
// frame and keeps a wrapping count of completed frames.
module proc_pix_counter #(
  parameter int N_PIX = 1024,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             accept,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             frame_done,
  output logic [7:0]       frame_count
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIX - 1);

  assign frame_done = accept && (pix_cnt == LAST_PIX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt     <= '0;
      frame_count <= 8'd0;
    end else if (accept) begin
      if (pix_cnt == LAST_PIX) begin
        pix_cnt     <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/proc_cfg_sequencer.sv
// Frame-synchronous configuration sequencer: holds shadow mode/kernel registers,
// gates the pixel stream and burst-loads the processor at frame boundaries.
module proc_cfg_sequencer
  import proc_cfg_sequencer_pkg::*;
#(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       host_we,
  input  logic [4:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic [7:0] host_rdata,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  output logic       proc_in_valid,
  output logic [7:0] proc_in_data,
  output logic       proc_reg_write_en,
  output logic [4:0] proc_reg_addr,
  output logic [7:0] proc_reg_wdata,
  input  logic [7:0] proc_reg_rdata,
  output logic       frame_done,
  output logic       busy
);

  localparam int N_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  seq_state_t                         state;
  logic [3:0]                         idx;
  logic                               pending;
  logic                               status_err;
  logic                               drop;
  logic [1:0]                         mode_q;
  logic [KERNEL_TAPS-1:0][7:0]        kernel_q;
  logic [CNT_W-1:0]                   pix_cnt;
  logic [7:0]                         frame_count;
  logic                               accept;
  logic                               in_burst;
  logic                               shadow_wr;
  logic                               commit;
  logic                               status_wr;
  logic                               frame_boundary;
  logic [3:0]                         host_koff;
  logic [3:0]                         kidx;

  assign accept        = src_valid && src_ready;
  assign proc_in_valid = accept;
  assign proc_in_data  = src_data;
  assign src_ready     = (state == ST_IDLE_STREAM) || (state == ST_WAIT_EOF);
  assign busy          = (state != ST_IDLE_STREAM);
  assign in_burst      = (state == ST_WRITE) || (state == ST_CHECK);

  assign shadow_wr = host_we && ((host_addr == HOST_MODE_ADDR) || is_kernel_addr(host_addr));
  assign commit    = host_we && (host_addr == HOST_CTRL_ADDR) && host_wdata[0];
  assign status_wr = host_we && (host_addr == HOST_STATUS_ADDR);
  assign host_koff = 4'(host_addr - HOST_KERNEL_FIRST);
  assign kidx      = idx - 4'd1;

  // An idle counter at zero is a boundary; so is the cycle that accepts the last pixel.
  assign frame_boundary = ((pix_cnt == '0) && !accept) || frame_done;

  proc_pix_counter #(
    .N_PIX (N_PIX),
    .CNT_W (CNT_W)
  ) u_pix_counter (
    .clk         (clk),
    .rstn        (rstn),
    .accept      (accept),
    .pix_cnt     (pix_cnt),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q   <= 2'd0;
      kernel_q <= '0;
      kernel_q[4] <= 8'd1;
    end else if (shadow_wr && !in_burst) begin
      if (host_addr == HOST_MODE_ADDR) begin
        mode_q <= host_wdata[1:0];
      end else begin
        kernel_q[host_koff] <= host_wdata;
      end
    end
  end

  // Status clears come first so a same-cycle error or drop still sticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE_STREAM;
      idx        <= 4'd0;
      pending    <= 1'b0;
      status_err <= 1'b0;
      drop       <= 1'b0;
    end else begin
      if (status_wr && host_wdata[2]) status_err <= 1'b0;
      if (status_wr && host_wdata[3]) drop <= 1'b0;
      if (shadow_wr && in_burst) drop <= 1'b1;
      unique case (state)
        ST_IDLE_STREAM: begin
          if (commit || pending) begin
            state   <= ST_WAIT_EOF;
            pending <= 1'b0;
          end
        end
        ST_WAIT_EOF: begin
          if (frame_boundary) begin
            state <= ST_WRITE;
            idx   <= 4'd0;
          end
        end
        ST_WRITE: begin
          if (commit) pending <= 1'b1;
          if (idx == LAST_WRITE_IDX) begin
            state <= ST_CHECK;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        ST_CHECK: begin
          if (commit) pending <= 1'b1;
          if (proc_reg_rdata != STATUS_MAGIC) status_err <= 1'b1;
          state <= ST_IDLE_STREAM;
        end
        default: state <= ST_IDLE_STREAM;
      endcase
    end
  end

  always_comb begin
    proc_reg_write_en = 1'b0;
    proc_reg_addr     = PROC_STATUS_ADDR;
    proc_reg_wdata    = 8'd0;
    if (state == ST_WRITE) begin
      proc_reg_write_en = 1'b1;
      if (idx == 4'd0) begin
        proc_reg_addr  = PROC_MODE_ADDR;
        proc_reg_wdata = {6'd0, mode_q};
      end else begin
        proc_reg_addr  = PROC_KERNEL_BASE + 5'(kidx);
        proc_reg_wdata = kernel_q[kidx];
      end
    end
  end

  always_comb begin
    host_rdata = 8'd0;
    if (host_addr == HOST_MODE_ADDR) begin
      host_rdata = {6'd0, mode_q};
    end else if (is_kernel_addr(host_addr)) begin
      host_rdata = kernel_q[host_koff];
    end else if (host_addr == HOST_STATUS_ADDR) begin
      host_rdata = {4'd0, drop, status_err, busy, pending};
    end else if (host_addr == HOST_FCOUNT_ADDR) begin
      host_rdata = frame_count;
    end
  end

endmodule

// File: tb/tb_proc_cfg_sequencer.sv
// Self-checking bench for proc_cfg_sequencer: host register table plus
// scoreboarded processor write bursts and frame-boundary corner cases.
module tb_proc_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       host_we = 1'b0;
  logic [4:0] host_addr = 5'd0;
  logic [7:0] host_wdata = 8'd0;
  logic [7:0] host_rdata;
  logic       src_valid = 1'b0;
  logic [7:0] src_data = 8'd0;
  logic       src_ready;
  logic       proc_in_valid;
  logic [7:0] proc_in_data;
  logic       proc_reg_write_en;
  logic [4:0] proc_reg_addr;
  logic [7:0] proc_reg_wdata;
  logic [7:0] proc_reg_rdata;
  logic       frame_done;
  logic       busy;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } host_vec_t;

  host_vec_t   vecs[$];
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          fd_cnt = 0;
  int          fd_at_acc = 0;
  int          low_cnt = 0;
  int          gate_err = 0;
  int          first_wr_acc = -1;
  logic [1:0]  m_mode;
  logic [7:0]  m_kernel[9];
  logic        bad_status = 1'b0;

  // Processor model: status register reads the magic value unless told otherwise.
  assign proc_reg_rdata = (proc_reg_addr == 5'h10) ? (bad_status ? 8'h55 : 8'hAA) : 8'h00;

  always #5 clk = ~clk;

  proc_cfg_sequencer #(
    .IMG_WIDTH  (32),
    .IMG_HEIGHT (32)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_rdata        (host_rdata),
    .src_valid         (src_valid),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .proc_in_valid     (proc_in_valid),
    .proc_in_data      (proc_in_data),
    .proc_reg_write_en (proc_reg_write_en),
    .proc_reg_addr     (proc_reg_addr),
    .proc_reg_wdata    (proc_reg_wdata),
    .proc_reg_rdata    (proc_reg_rdata),
    .frame_done        (frame_done),
    .busy              (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [7:0] wdata);
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
  endtask

  function automatic void resetModel();
    m_mode = 2'd0;
    for (int i = 0; i < 9; i++) m_kernel[i] = (i == 4) ? 8'd1 : 8'd0;
  endfunction

  function automatic void updateModel(input logic [4:0] addr, input logic [7:0] data);
    if (addr == 5'h00) m_mode = data[1:0];
    else if (addr >= 5'h04 && addr <= 5'h0C) m_kernel[int'(addr) - 4] = data;
  endfunction

  function automatic void addVec(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp);
    host_vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic void pushBurst(input int count);
    logic [12:0] full[10];
    full[0] = {5'h00, 6'd0, m_mode};
    for (int i = 0; i < 9; i++) full[i+1] = {5'(4 + i), m_kernel[i]};
    for (int i = 0; i < count; i++) exp_q.push_back(full[i]);
  endfunction

  // Observe the DUT a little after the input change, then advance to the next negedge.
  task automatic cycle();
    #2;
    if (proc_in_valid !== (src_valid && src_ready) || proc_in_data !== src_data) gate_err++;
    if (src_valid && src_ready) acc_cnt++;
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_at_acc = acc_cnt;
    end
    if (src_ready !== 1'b1) low_cnt++;
    if (proc_reg_write_en === 1'b1) begin
      obs_q.push_back({proc_reg_addr, proc_reg_wdata});
      if (first_wr_acc < 0) first_wr_acc = acc_cnt;
    end
    @(negedge clk);
  endtask

  task automatic hostWrite(input logic [4:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data);
    updateModel(addr, data);
    cycle();
    applyStimulus(1'b0, 5'd0, 8'd0);
  endtask

  task automatic hostRead(input string name, input logic [4:0] addr, input logic [7:0] exp);
    applyStimulus(1'b0, addr, 8'd0);
    #1;
    checkOutput(name, host_rdata, exp);
    cycle();
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      src_data = 8'(n);
      cycle();
      n++;
    end
    checkOutput("wait for idle", busy, 0);
  endtask

  task automatic drainScoreboard(input string name);
    int n;
    checkOutput($sformatf("%s write count", name), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s write %0d {addr,data}", name, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " src_ready"}, src_ready, 1);
    checkOutput({tag, " proc_reg_write_en"}, proc_reg_write_en, 0);
    checkOutput({tag, " proc_reg_addr"}, proc_reg_addr, 5'h10);
    checkOutput({tag, " proc_reg_wdata"}, proc_reg_wdata, 0);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " busy"}, busy, 0);
  endtask

  initial begin
    resetModel();

    addVec(1'b0, 5'h00, 8'h00, 8'h00);
    addVec(1'b0, 5'h08, 8'h00, 8'h01);
    addVec(1'b0, 5'h11, 8'h00, 8'h00);
    addVec(1'b0, 5'h12, 8'h00, 8'h00);
    addVec(1'b0, 5'h04, 8'h00, 8'h00);
    addVec(1'b0, 5'h10, 8'h00, 8'h00);
    addVec(1'b0, 5'h1F, 8'h00, 8'h00);
    addVec(1'b1, 5'h1F, 8'hFF, 8'h00);
    addVec(1'b0, 5'h1F, 8'h00, 8'h00);
    addVec(1'b1, 5'h00, 8'hFF, 8'h00);
    addVec(1'b0, 5'h00, 8'h00, 8'h03);
    addVec(1'b1, 5'h00, 8'h02, 8'h00);
    addVec(1'b0, 5'h00, 8'h00, 8'h02);
    for (int i = 4; i <= 12; i++) addVec(1'b1, 5'(i), 8'h01, 8'h00);
    addVec(1'b0, 5'h04, 8'h00, 8'h01);
    addVec(1'b0, 5'h08, 8'h00, 8'h01);
    addVec(1'b0, 5'h0C, 8'h00, 8'h01);

    @(negedge clk);
    @(negedge clk);
    #1;
    checkResetOutputs("in reset");
    @(negedge clk);
    rstn = 1'b1;

    // Host register table.
    foreach (vecs[k]) begin
      if (vecs[k].we) begin
        hostWrite(vecs[k].addr, vecs[k].wdata);
      end else begin
        hostRead($sformatf("vec%0d read 0x%0h", k, vecs[k].addr), vecs[k].addr, vecs[k].exp);
      end
    end

    // One full frame of pixels.
    acc_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      src_valid = 1'b1;
      src_data  = 8'(i);
      cycle();
    end
    src_valid = 1'b0;
    checkOutput("frame_done pulses", fd_cnt, 1);
    checkOutput("frame_done on pixel", fd_at_acc, 1024);
    hostRead("frame count after one frame", 5'h12, 8'h01);

    // Commit while idle at a frame boundary.
    low_cnt = 0;
    pushBurst(10);
    applyStimulus(1'b1, 5'h10, 8'h01);
    #1 checkOutput("busy on commit cycle", busy, 0);
    cycle();
    applyStimulus(1'b0, 5'd0, 8'd0);
    #1 checkOutput("busy in WAIT_EOF", busy, 1);
    checkOutput("src_ready in WAIT_EOF", src_ready, 1);
    cycle();
    #1 checkOutput("first write enable", proc_reg_write_en, 1);
    checkOutput("first write addr", proc_reg_addr, 5'h00);
    checkOutput("src_ready in WRITE", src_ready, 0);
    cycle();
    waitIdle(40);
    checkOutput("src_ready low cycles", low_cnt, 11);
    drainScoreboard("idle burst");
    hostRead("status after good burst", 5'h11, 8'h00);

    // Commit mid-frame with a continuous stream.
    hostWrite(5'h00, 8'h01);
    hostWrite(5'h04, 8'h33);
    acc_cnt = 0;
    for (int i = 0; i < 500; i++) begin
      src_valid = 1'b1;
      src_data  = 8'(i);
      cycle();
    end
    pushBurst(10);
    applyStimulus(1'b1, 5'h10, 8'h01);
    cycle();
    applyStimulus(1'b0, 5'd0, 8'd0);
    acc_cnt = 0; fd_cnt = 0; low_cnt = 0; first_wr_acc = -1;
    waitIdle(2000);
    checkOutput("pixels before burst", first_wr_acc, 523);
    checkOutput("frame_done before burst", fd_cnt, 1);
    checkOutput("stall cycles mid-frame", low_cnt, 11);
    drainScoreboard("mid-frame burst");
    #1 checkOutput("ready after burst", src_ready, 1);
    acc_cnt = 0; fd_cnt = 0;
    for (int n = 0; n < 1100 && fd_cnt == 0; n++) begin
      src_data = 8'(n + 7);
      cycle();
    end
    src_valid = 1'b0;
    checkOutput("next frame length", fd_at_acc, 1024);
    hostRead("frame count after three frames", 5'h12, 8'h03);

    // Bad processor status sets the sticky error bit.
    bad_status = 1'b1;
    pushBurst(10);
    hostWrite(5'h10, 8'h01);
    waitIdle(40);
    bad_status = 1'b0;
    drainScoreboard("bad-status burst");
    hostRead("status err set", 5'h11, 8'h04);
    hostWrite(5'h11, 8'h04);
    hostRead("status err cleared", 5'h11, 8'h00);

    // Shadow write and commit during WRITE.
    pushBurst(10);
    pushBurst(10);
    hostWrite(5'h10, 8'h01);
    cycle();
    applyStimulus(1'b1, 5'h05, 8'h77);
    cycle();
    applyStimulus(1'b1, 5'h10, 8'h01);
    cycle();
    hostRead("status during burst", 5'h11, 8'h0B);
    waitIdle(40);
    cycle();
    waitIdle(40);
    drainScoreboard("double burst");
    hostRead("dropped shadow write", 5'h05, m_kernel[1]);
    hostRead("status drop set", 5'h11, 8'h08);
    hostWrite(5'h11, 8'h08);
    hostRead("status drop cleared", 5'h11, 8'h00);

    // Reset in the middle of a burst.
    pushBurst(4);
    hostWrite(5'h10, 8'h01);
    for (int i = 0; i < 5; i++) cycle();
    rstn = 1'b0;
    resetModel();
    #1;
    checkResetOutputs("mid-burst reset");
    cycle();
    cycle();
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    drainScoreboard("aborted burst");
    hostRead("status after reset", 5'h11, 8'h00);
    hostRead("mode after reset", 5'h00, {6'd0, m_mode});
    hostRead("k4 after reset", 5'h08, m_kernel[4]);
    checkOutput("pixel gate errors", gate_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
